// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan, row sync, debounce, ghost reject, one hex code per press (KEYPAD_REPEAT_EN adds auto-repeat).
// Latency: DEBOUNCE_SCANS full scans + up to 1 scan alignment + 2 sync cycles + 1 cycle from a clean press to key_valid.
// Backpressure: none; key_valid is a single-cycle pulse that the consumer must take when it appears.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]    DB       = 4'(DEBOUNCE_SCANS);
    // Candidate encoding: {none, col*4+row}
    localparam logic [4:0]    NONE     = 5'h10;

    typedef enum logic [1:0] {RELEASED, HELD, RELEASE_WAIT} state_t;

    state_t        state, state_n;
    logic [3:0]    row_meta, row_sync;
    logic [DW-1:0] div;
    logic [1:0]    col_idx;
    logic [15:0]   snapshot;
    logic          eval;
    logic [4:0]    cand, prev_cand, held_cand;
    logic [3:0]    stable_cnt, cnt_next;
    logic          stable_ok;
    logic          accept;
    logic          rpt_fire;

    function automatic logic [3:0] keymap(input logic [3:0] idx);
        case (idx)
            4'd0:  return 4'h1;
            4'd1:  return 4'h4;
            4'd2:  return 4'h7;
            4'd3:  return 4'h0;
            4'd4:  return 4'h2;
            4'd5:  return 4'h5;
            4'd6:  return 4'h8;
            4'd7:  return 4'hF;
            4'd8:  return 4'h3;
            4'd9:  return 4'h6;
            4'd10: return 4'h9;
            4'd11: return 4'hE;
            4'd12: return 4'hA;
            4'd13: return 4'hB;
            4'd14: return 4'hC;
            default: return 4'hD;
        endcase
    endfunction

    assign col = ~(4'b0001 << col_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            div      <= '0;
            col_idx  <= 2'd0;
            snapshot <= '0;
            eval     <= 1'b0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            eval     <= 1'b0;
            if (div == DIV_LAST) begin
                div                           <= '0;
                snapshot[{col_idx, 2'b00} +: 4] <= row_sync;
                col_idx                       <= col_idx + 2'd1;
                eval                          <= (col_idx == 2'd3);
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    // Exactly one pressed bit is a key; none or several is treated as no key
    always_comb begin
        logic [15:0] pressed;
        logic [4:0]  hits;
        logic [3:0]  idx;
        pressed = ~snapshot;
        hits    = 5'd0;
        idx     = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pressed[i]) begin
                hits = hits + 5'd1;
                idx  = 4'(i);
            end
        end
        cand = (hits == 5'd1) ? {1'b0, idx} : NONE;
    end

    assign cnt_next  = (cand != prev_cand) ? 4'd1 :
                       (stable_cnt >= DB)  ? DB   : stable_cnt + 4'd1;
    assign stable_ok = (cnt_next == DB);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            RELEASED: begin
                if (eval && cand != NONE && stable_ok) begin
                    state_n = HELD;
                    accept  = 1'b1;
                end
            end
            HELD: begin
                if (eval && cand != held_cand)
                    state_n = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (eval) begin
                    if (cand == held_cand)
                        state_n = HELD;
                    else if (cand == NONE && stable_ok)
                        state_n = RELEASED;
                end
            end
            default: state_n = RELEASED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RELEASED;
            prev_cand  <= NONE;
            stable_cnt <= 4'd0;
            held_cand  <= NONE;
            key_code   <= 4'h0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            state     <= state_n;
            key_valid <= accept | rpt_fire;
            key_held  <= (state_n != RELEASED);
            if (eval) begin
                prev_cand  <= cand;
                stable_cnt <= cnt_next;
            end
            if (accept) begin
                held_cand <= cand;
                key_code  <= keymap(cand[3:0]);
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [15:0] rpt_cnt;
    logic [15:0] rpt_limit;
    logic        rpt_first;

    // First repeat waits REPEAT_DELAY scans, later ones REPEAT_RATE scans
    always_comb begin
        rpt_limit = rpt_first ? 16'(REPEAT_DELAY) : 16'(REPEAT_RATE);
        rpt_fire  = 1'b0;
        if (eval && state == HELD && state_n == HELD)
            rpt_fire = ((rpt_cnt + 16'd1) >= rpt_limit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state_n != HELD) begin
            rpt_cnt   <= 16'd0;
            rpt_first <= 1'b1;
        end else if (eval && state == HELD) begin
            if (rpt_fire) begin
                rpt_cnt   <= 16'd0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DELAY, REPEAT_RATE};
    assign rpt_fire   = 1'b0;
`endif

endmodule
